branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
Branch-resolution and program-counter stage for the RV32I single-cycle core.
- Supplies the signed/unsigned select to the less-than comparator.
- Consumes its result together with an equality flag, decides branch/jump direction and computes the target.
- Owns the PC register, with a misaligned-target trap path and saturating branch statistics counters for bring-up and debug.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
TRAP_VEC, 32'h0000_0100, PC loaded when a misaligned taken target is detected
CNT_W, 16, width of each statistics counter

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_stall  input  1  hold PC, state and counters this cycle
i_br_en  input  1  current instruction is a conditional branch
i_jal  input  1  current instruction is JAL
i_jalr  input  1  current instruction is JALR
i_funct3  input  3  branch funct3 field
i_less  input  1  less-than result from comparator
i_equal  input  1  rs1 == rs2
i_rs1  input  32  rs1 value (JALR base)
i_imm  input  32  sign-extended immediate
i_cnt_clr  input  1  synchronous clear of statistics counters
o_br_signed  output  1  signed-compare select to comparator
o_pc  output  32  current PC
o_pc_four  output  32  o_pc + 4 (link value)
o_taken  output  1  control transfer taken this cycle
o_trap  output  1  one-cycle pulse, in TRAP state
o_bad_addr  output  32  last misaligned target captured
o_illegal_br  output  1  sticky: branch with funct3 010/011 seen
o_br_cnt  output  CNT_W  conditional branches retired
o_taken_cnt  output  CNT_W  conditional branches taken

Behaviour:
- Reset values, asynchronous on i_rst_n=0:
  - o_pc=RESET_PC; state=RUN.
  - o_bad_addr=0; o_illegal_br=0; both counters=0.
  - o_trap=0.
- Combinational outputs:
  - o_br_signed = ~i_funct3[1].
  - o_pc_four = o_pc+4, mod 2^32.
- Branch condition by funct3:
  - 000: i_equal.
  - 001: ~i_equal.
  - 100, 110: i_less.
  - 101, 111: ~i_less.
  - 010, 011: illegal; never taken, and o_illegal_br is set (sticky until reset) on a non-stalled RUN cycle.
- o_taken = (i_br_en & cond) | i_jal | i_jalr.
- Jump priority: i_jalr > i_jal > i_br_en.
- Target:
  - JALR: (i_rs1+i_imm) & ~1.
  - JAL/branch: o_pc+i_imm.
  - All additions 32-bit, wrap-around, no overflow flag.
- Next PC: o_taken ? target : o_pc_four.
- State machine:
  - RUN, no stall, o_taken=1 with target[1:0]!=0: go to TRAP; o_pc<=TRAP_VEC; o_bad_addr<=target; counters update normally.
  - RUN, no stall, otherwise: o_pc<=next PC; stay in RUN.
  - TRAP: o_trap=1 for exactly one cycle; inputs ignored, including i_stall; o_pc holds TRAP_VEC; no counter update; unconditionally returns to RUN.
- i_stall=1 in RUN: o_pc, state, counters and sticky flags hold. o_taken still reflects the inputs combinationally.
- Counters, non-stalled RUN cycles only:
  - o_br_cnt increments when i_br_en=1.
  - o_taken_cnt increments when i_br_en & cond.
  - Both saturate at 2^CNT_W-1.
  - i_cnt_clr clears both, overriding a same-cycle increment. Clear also acts in TRAP and while stalled.
- Reset asserted mid-TRAP: immediate return to RUN, o_pc=RESET_PC.
- Latency: PC update is visible the cycle after the edge; there is no additional pipeline.

Test Plan:
- Reset release, no branches, 4 cycles -> o_pc 0x0,0x4,0x8,0xC; o_taken=0; counters 0.
- o_pc=0x10, BEQ funct3=000, i_equal=1, i_imm=0x20 -> o_taken=1; next o_pc=0x30; o_br_cnt=1; o_taken_cnt=1.
- BLTU funct3=110 -> o_br_signed=0; i_less=0 -> not taken, o_pc+4, o_taken_cnt unchanged. BGE funct3=101 -> o_br_signed=1.
- JALR i_rs1=0x103, i_imm=0 -> target 0x102 -> o_pc=TRAP_VEC, o_bad_addr=0x102, o_trap pulse 1 cycle, then PC advances to 0x104.
- i_stall=1 for 3 cycles during a taken JAL -> o_pc and counters frozen; after release the jump occurs once, o_br_cnt unchanged.
- CNT_W=2: 5 taken branches with i_cnt_clr on the 5th -> counts saturate at 3, then read 0. funct3=011 branch -> o_illegal_br=1, held until reset.

Source files
------------

// File: rtl/branch_pc_unit.sv
// Purpose : RV32I branch resolution, jump/branch target generation, PC register,
//           misaligned-target trap and saturating branch statistics.
// Latency : combinational decision; PC/state/counter updates visible one cycle after the edge.
// Backpr. : i_stall holds PC, state, sticky flag and counters (RUN only); TRAP ignores it.
//
// Ports:
//   i_clk, i_rst_n       clock (rising edge), asynchronous active-low reset
//   i_stall              freeze PC/state/counters/sticky flag this cycle (RUN)
//   i_br_en/i_jal/i_jalr instruction class: conditional branch, JAL, JALR
//   i_funct3             branch condition select
//   i_less, i_equal      comparator results for rs1 vs rs2
//   i_rs1, i_imm         JALR base and sign-extended immediate
//   i_cnt_clr            synchronous clear of both statistics counters
//   o_br_signed          signed-compare select driven back to the comparator
//   o_pc, o_pc_four      current PC and its link value
//   o_taken              control transfer taken this cycle (combinational)
//   o_trap               high for the single cycle spent in TRAP
//   o_bad_addr           last misaligned taken target
//   o_illegal_br         sticky: branch with reserved funct3 (010/011) retired
//   o_br_cnt             conditional branches retired (saturating)
//   o_taken_cnt          conditional branches taken (saturating)

module branch_pc_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_VEC = 32'h0000_0100,
   parameter int          CNT_W    = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_stall,
   input  logic             i_br_en,
   input  logic             i_jal,
   input  logic             i_jalr,
   input  logic [2:0]       i_funct3,
   input  logic             i_less,
   input  logic             i_equal,
   input  logic [31:0]      i_rs1,
   input  logic [31:0]      i_imm,
   input  logic             i_cnt_clr,
   output logic             o_br_signed,
   output logic [31:0]      o_pc,
   output logic [31:0]      o_pc_four,
   output logic             o_taken,
   output logic             o_trap,
   output logic [31:0]      o_bad_addr,
   output logic             o_illegal_br,
   output logic [CNT_W-1:0] o_br_cnt,
   output logic [CNT_W-1:0] o_taken_cnt
);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_TRAP = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   state_t           state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      bad_q, bad_d;
   logic             ill_q, ill_d;
   logic [CNT_W-1:0] br_cnt_q, br_cnt_d;
   logic [CNT_W-1:0] tk_cnt_q, tk_cnt_d;

   logic             cond;
   logic             f3_illegal;
   logic             br_taken;
   logic             taken;
   logic [31:0]      pc_four;
   logic [31:0]      jalr_sum;
   logic [31:0]      target;
   logic             misaligned;
   logic             run_go;

   // ------------------------------------------------------------------
   // Branch condition decode
   // ------------------------------------------------------------------
   always_comb begin
      cond = 1'b0;
      case (i_funct3)
         3'b000:         cond = i_equal;
         3'b001:         cond = ~i_equal;
         3'b100, 3'b110: cond = i_less;
         3'b101, 3'b111: cond = ~i_less;
         default:        cond = 1'b0;   // 010/011 reserved: never taken
      endcase
   end

   assign f3_illegal = (i_funct3[2:1] == 2'b01);
   assign br_taken   = i_br_en & cond;
   assign taken      = br_taken | i_jal | i_jalr;

   // Unsigned variants (BLTU/BGEU) have funct3[1] set.
   assign o_br_signed = ~i_funct3[1];

   // ------------------------------------------------------------------
   // Target generation; JALR wins over JAL, JAL over branch. JAL and
   // branches share the PC-relative adder.
   // ------------------------------------------------------------------
   assign pc_four  = pc_q + 32'd4;
   assign jalr_sum = i_rs1 + i_imm;
   assign target   = i_jalr ? {jalr_sum[31:1], 1'b0} : (pc_q + i_imm);

   // JALR already clears bit 0, so only bit 1 can flag it; branch/JAL can
   // trip on either bit.
   assign misaligned = taken & (target[1:0] != 2'b00);

   assign run_go = (state_q == S_RUN) & ~i_stall;

   // ------------------------------------------------------------------
   // State / PC next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      bad_d   = bad_q;
      ill_d   = ill_q;
      case (state_q)
         S_RUN: begin
            if (!i_stall) begin
               if (misaligned) begin
                  state_d = S_TRAP;
                  pc_d    = TRAP_VEC;
                  bad_d   = target;
               end else begin
                  pc_d    = taken ? target : pc_four;
               end
               if (i_br_en && f3_illegal) begin
                  ill_d = 1'b1;
               end
            end
         end
         S_TRAP: begin
            // PC already holds TRAP_VEC; every input, stall included, is
            // ignored for this one cycle.
            state_d = S_RUN;
         end
         default: begin
            state_d = S_RUN;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Saturating statistics counters; clear beats increment and acts in
   // any state, stalled or not.
   // ------------------------------------------------------------------
   always_comb begin
      br_cnt_d = br_cnt_q;
      tk_cnt_d = tk_cnt_q;
      if (i_cnt_clr) begin
         br_cnt_d = '0;
         tk_cnt_d = '0;
      end else if (run_go) begin
         if (i_br_en && (br_cnt_q != CNT_MAX)) begin
            br_cnt_d = br_cnt_q + CNT_W'(1);
         end
         if (br_taken && (tk_cnt_q != CNT_MAX)) begin
            tk_cnt_d = tk_cnt_q + CNT_W'(1);
         end
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= S_RUN;
         pc_q     <= RESET_PC;
         bad_q    <= '0;
         ill_q    <= 1'b0;
         br_cnt_q <= '0;
         tk_cnt_q <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         bad_q    <= bad_d;
         ill_q    <= ill_d;
         br_cnt_q <= br_cnt_d;
         tk_cnt_q <= tk_cnt_d;
      end
   end

   assign o_pc         = pc_q;
   assign o_pc_four    = pc_four;
   assign o_taken      = taken;
   assign o_trap       = (state_q == S_TRAP);
   assign o_bad_addr   = bad_q;
   assign o_illegal_br = ill_q;
   assign o_br_cnt     = br_cnt_q;
   assign o_taken_cnt  = tk_cnt_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Purpose : self-checking bench for branch_pc_unit (2-bit counters to reach saturation).
// Latency : one vector per clock; post-edge state popped from a scoreboard queue.
// Backpr. : stall exercised through vectors; no handshake on the bench side.

module tb_branch_pc_unit;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] TRAP_VEC = 32'h0000_0100;
   localparam int          CNT_W    = 2;

   logic             clk;
   logic             rst_n;
   logic             stall, br_en, jal, jalr, less, equal, cnt_clr;
   logic [2:0]       funct3;
   logic [31:0]      rs1, imm;
   logic             br_signed, taken, trap, illegal_br;
   logic [31:0]      pc, pc_four, bad_addr;
   logic [CNT_W-1:0] br_cnt, taken_cnt;

   branch_pc_unit #(
      .RESET_PC(RESET_PC),
      .TRAP_VEC(TRAP_VEC),
      .CNT_W   (CNT_W)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_stall     (stall),
      .i_br_en     (br_en),
      .i_jal       (jal),
      .i_jalr      (jalr),
      .i_funct3    (funct3),
      .i_less      (less),
      .i_equal     (equal),
      .i_rs1       (rs1),
      .i_imm       (imm),
      .i_cnt_clr   (cnt_clr),
      .o_br_signed (br_signed),
      .o_pc        (pc),
      .o_pc_four   (pc_four),
      .o_taken     (taken),
      .o_trap      (trap),
      .o_bad_addr  (bad_addr),
      .o_illegal_br(illegal_br),
      .o_br_cnt    (br_cnt),
      .o_taken_cnt (taken_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        br_en, jal, jalr;
      logic [2:0]  f3;
      logic        less, equal;
      logic [31:0] rs1, imm;
      logic        stall, clr;
      logic        e_taken;
      logic [31:0] e_pc;
      logic [1:0]  e_br, e_tk;
      logic        e_trap;
      logic [31:0] e_bad;
      logic        e_ill;
   } vec_t;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  br, tk;
      logic        trap;
      logic [31:0] bad;
      logic        ill;
   } exp_t;

   exp_t        sb[$];
   int          n_pass  = 0;
   int          n_total = 0;
   logic [31:0] cur_pc;
   vec_t        tbl[17];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic vec_t mkv(
      input logic b, input logic j, input logic jr, input logic [2:0] f,
      input logic l, input logic e, input logic [31:0] r, input logic [31:0] im,
      input logic s, input logic c, input logic et, input logic [31:0] ep,
      input logic [1:0] eb, input logic [1:0] ek, input logic etr,
      input logic [31:0] ebad, input logic eill);
      vec_t v;
      v.br_en = b;  v.jal = j;  v.jalr = jr; v.f3 = f;
      v.less = l;   v.equal = e; v.rs1 = r;  v.imm = im;
      v.stall = s;  v.clr = c;
      v.e_taken = et; v.e_pc = ep; v.e_br = eb; v.e_tk = ek;
      v.e_trap = etr; v.e_bad = ebad; v.e_ill = eill;
      return v;
   endfunction

   // Called on a falling edge; leaves the bench on the next falling edge.
   task automatic step(input vec_t v, input string tag);
      exp_t e;
      logic exp_signed;
      br_en = v.br_en; jal = v.jal; jalr = v.jalr; funct3 = v.f3;
      less = v.less; equal = v.equal; rs1 = v.rs1; imm = v.imm;
      stall = v.stall; cnt_clr = v.clr;
      #1;
      exp_signed = ~v.f3[1];
      chk({tag, " taken"},   {31'd0, taken},     {31'd0, v.e_taken});
      chk({tag, " signed"},  {31'd0, br_signed}, {31'd0, exp_signed});
      chk({tag, " pc_four"}, pc_four, cur_pc + 32'd4);
      e.pc = v.e_pc; e.br = v.e_br; e.tk = v.e_tk;
      e.trap = v.e_trap; e.bad = v.e_bad; e.ill = v.e_ill;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({tag, " pc"},       pc,                     e.pc);
      chk({tag, " br_cnt"},   {30'd0, br_cnt},        {30'd0, e.br});
      chk({tag, " tk_cnt"},   {30'd0, taken_cnt},     {30'd0, e.tk});
      chk({tag, " trap"},     {31'd0, trap},          {31'd0, e.trap});
      chk({tag, " bad_addr"}, bad_addr,               e.bad);
      chk({tag, " illegal"},  {31'd0, illegal_br},    {31'd0, e.ill});
      cur_pc = e.pc;
      @(negedge clk);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t idle;
      rst_n = 1'b1;
      stall = 0; br_en = 0; jal = 0; jalr = 0; funct3 = 3'b000;
      less = 0; equal = 0; rs1 = 0; imm = 0; cnt_clr = 0;
      cur_pc = RESET_PC;

      // Table: {inputs, expected taken, next PC, br_cnt, taken_cnt, trap, bad, illegal}
      tbl[0]  = mkv(0,0,0,3'b000,0,0,0,0,0,0,                       0,32'h04,  0,0,0,0,0);
      tbl[1]  = mkv(0,0,0,3'b000,0,0,0,0,0,0,                       0,32'h08,  0,0,0,0,0);
      tbl[2]  = mkv(0,0,0,3'b000,0,0,0,0,0,0,                       0,32'h0C,  0,0,0,0,0);
      tbl[3]  = mkv(0,0,0,3'b000,0,0,0,0,0,0,                       0,32'h10,  0,0,0,0,0);
      tbl[4]  = mkv(1,0,0,3'b000,0,1,0,32'h20,0,0,                  1,32'h30,  1,1,0,0,0);
      tbl[5]  = mkv(1,0,0,3'b110,0,0,0,32'h40,0,0,                  0,32'h34,  2,1,0,0,0);
      tbl[6]  = mkv(1,0,0,3'b101,0,0,0,32'h08,0,0,                  1,32'h3C,  3,2,0,0,0);
      tbl[7]  = mkv(1,0,0,3'b001,0,0,0,32'hFFFF_FFFC,0,1,           1,32'h38,  0,0,0,0,0);
      tbl[8]  = mkv(0,1,0,3'b000,0,0,0,32'h100,0,0,                 1,32'h138, 0,0,0,0,0);
      tbl[9]  = mkv(1,0,0,3'b100,1,0,0,32'h10,0,0,                  1,32'h148, 1,1,0,0,0);
      tbl[10] = mkv(1,0,0,3'b111,1,0,0,32'h10,0,0,                  0,32'h14C, 2,1,0,0,0);
      tbl[11] = mkv(1,1,1,3'b000,0,0,32'h1000,32'h11,0,0,           1,32'h1010,3,1,0,0,0);
      tbl[12] = mkv(1,1,0,3'b000,0,1,0,32'h40,1,0,                  1,32'h1010,3,1,0,0,0);
      tbl[13] = mkv(1,0,0,3'b010,1,1,0,32'h40,1,1,                  0,32'h1010,0,0,0,0,0);
      tbl[14] = mkv(0,1,0,3'b000,0,0,0,32'hFFFF_EFF0,0,0,           1,32'h0,   0,0,0,0,0);
      tbl[15] = mkv(0,0,1,3'b000,0,0,32'hFFFF_FFF0,32'h20,0,0,      1,32'h10,  0,0,0,0,0);
      tbl[16] = mkv(1,0,0,3'b011,1,1,0,32'h40,0,0,                  0,32'h14,  1,0,0,0,1);

      // Reset state
      #2 rst_n = 1'b0;
      #1;
      chk("rst pc",       pc,                  RESET_PC);
      chk("rst trap",     {31'd0, trap},       32'd0);
      chk("rst bad_addr", bad_addr,            32'd0);
      chk("rst illegal",  {31'd0, illegal_br}, 32'd0);
      chk("rst br_cnt",   {30'd0, br_cnt},     32'd0);
      chk("rst tk_cnt",   {30'd0, taken_cnt},  32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < 17; i++) begin
         step(tbl[i], $sformatf("vec%0d", i));
      end

      // Misaligned JALR: trap, stall and branch ignored in TRAP, then resume.
      step(mkv(0,0,1,3'b000,0,0,32'h103,0,0,0, 1,TRAP_VEC,1,0,1,32'h102,1), "jalr_trap");
      step(mkv(1,0,0,3'b000,0,0,0,0,1,0,       0,TRAP_VEC,1,0,0,32'h102,1), "in_trap1");
      idle = mkv(0,0,0,3'b000,0,0,0,0,0,0,     0,32'h104, 1,0,0,32'h102,1);
      step(idle, "post_trap1");

      // Misaligned branch: counters still update; clear acts during TRAP.
      step(mkv(1,0,0,3'b000,0,1,0,32'h2,0,0,   1,TRAP_VEC,2,1,1,32'h106,1), "br_trap");
      step(mkv(0,0,0,3'b000,0,0,0,0,0,1,       0,TRAP_VEC,0,0,0,32'h106,1), "in_trap2");
      step(mkv(0,0,0,3'b000,0,0,0,0,0,0,       0,32'h104, 0,0,0,32'h106,1), "post_trap2");

      // Stalled JAL for 3 cycles, then the jump happens once.
      for (int i = 0; i < 3; i++) begin
         step(mkv(0,1,0,3'b000,0,0,0,32'h10,1,0, 1,32'h104,0,0,0,32'h106,1),
              $sformatf("stall%0d", i));
      end
      step(mkv(0,1,0,3'b000,0,0,0,32'h10,0,0,  1,32'h114,0,0,0,32'h106,1), "jal_release");

      // Saturation at 3 then clear overriding the 5th increment.
      for (int i = 0; i < 4; i++) begin
         logic [1:0] c;
         c = (i >= 2) ? 2'd3 : 2'(i + 1);
         step(mkv(1,0,0,3'b000,0,1,0,32'h4,0,0, 1,32'h118 + 32'(4*i),c,c,0,32'h106,1),
              $sformatf("sat%0d", i));
      end
      step(mkv(1,0,0,3'b000,0,1,0,32'h4,0,1,   1,32'h128,0,0,0,32'h106,1), "sat_clr");

      // Misaligned JAL, then reset asserted while in TRAP.
      step(mkv(0,1,0,3'b000,0,0,0,32'h1,0,0,   1,TRAP_VEC,0,0,1,32'h129,1), "jal_trap");
      rst_n = 1'b0;
      #1;
      chk("midtrap_rst pc",      pc,                  RESET_PC);
      chk("midtrap_rst trap",    {31'd0, trap},       32'd0);
      chk("midtrap_rst illegal", {31'd0, illegal_br}, 32'd0);
      chk("midtrap_rst bad",     bad_addr,            32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      cur_pc = RESET_PC;
      step(mkv(0,0,0,3'b000,0,0,0,0,0,0,       0,32'h4,0,0,0,0,0), "after_rst");

      chk("scoreboard empty", sb.size(), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
